sync_fifo_ctl: RTL and testbench
================================

Name: sync_fifo_ctl

Overview:
- Single-clock, parametrised FIFO with programmable almost-full/almost-empty thresholds, a fill count and sticky overflow/underflow error flags.
- Selectable read mode: standard registered read, or first-word-fall-through (FWFT).
- Synchronous flush input.
- Companion to the dual-clock FIFO; used wherever producer and consumer share one clock (datapath staging, DDS sample buffering).

Parameters:
- DATA_W, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AFULL_TH, 12, w_almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 2, r_almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.
- FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFO contents.
- w_en  in  1  write request.
- w_data  in  DATA_W  write data.
- r_en  in  1  read/pop request.
- r_data  out  DATA_W  read data.
- r_valid  out  1  r_data is valid.
- w_full  out  1  count == DEPTH.
- w_almost_full  out  1  count >= AFULL_TH.
- r_empty  out  1  count == 0.
- r_almost_empty  out  1  count <= AEMPTY_TH.
- fill_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

Behaviour:
- Single clock; reset is synchronous and active-high.
- Reset values: r_data=0, r_valid=0, w_full=0, w_almost_full=0, r_empty=1, r_almost_empty=1, fill_count=0, overflow=0, underflow=0. Read and write pointers reset to 0.
- Priority: rst > flush > w_en/r_en.
- flush: pointers and count go to 0 and flags take their empty values on the next edge. r_valid=0. Sticky error flags are NOT cleared; only rst clears them. Any w_en/r_en in the same cycle is ignored.
- Pointers are clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accept rules, evaluated against the registered state before the edge:
  - wr_acc = w_en & ~w_full
  - rd_acc = r_en & ~r_empty
- Next count = count + wr_acc - rd_acc.
- All status flags are registered and reflect the post-edge count (one-cycle latency from request to flag).
- Full with w_en and r_en both high: the read is accepted, the write is rejected, overflow is set. Count goes DEPTH -> DEPTH-1.
- Empty with w_en and r_en both high: the write is accepted, the read is rejected, underflow is set. Count goes 0 -> 1. This applies in both modes.
- Non-full, non-empty with both high: both are accepted; count is unchanged.
- Standard mode (FWFT=0):
  - On rd_acc, r_data is loaded with mem[rd_ptr] at the edge and r_valid=1 for that cycle only.
  - Otherwise r_data holds its value and r_valid=0.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - r_data = mem[rd_ptr] continuously (combinational read) and r_valid = ~r_empty.
  - r_en acts as a pop acknowledge.
  - A word written into an empty FIFO appears on r_data one cycle after the write edge.
- Memory is written at mem[wr_ptr] on wr_acc. A read-during-write to the same address cannot occur, because an empty FIFO rejects the read.
- overflow and underflow set on the first offending cycle and hold until rst.

Decomposition:
- Shared package/header sync_fifo_pkg:
  - clog2 constant function.
  - Mode constants FIFO_STD=0 and FIFO_FWFT=1.
  - Parameter-legality checks, a simulation-time error if DEPTH is not a power of two or a threshold is out of range.
- One sub-module, sfifo_ram: simple dual-port RAM, DATA_W x DEPTH, synchronous write, asynchronous read. The controller adds the output register in standard mode.

Test Plan (all scenarios use DATA_W=32, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2):
- Reset and fill:
  - Stimulus: rst high 3 cycles, then write 1..16 on consecutive cycles.
  - Response: after 12 writes w_almost_full=1. After 16 writes w_full=1, fill_count=16. r_almost_empty=1 through count=2 and deasserts at count=3.
- Overflow and drain:
  - Stimulus: from full, one extra write 0xDEAD, then drain 16 reads (FWFT=0).
  - Response: overflow=1 and stays set. r_data is 1..16 in order, each with a single-cycle r_valid one cycle after r_en. 0xDEAD never appears. r_empty=1 at the end.
- Underflow:
  - Stimulus: r_en on empty.
  - Response: underflow=1, r_valid=0, fill_count stays 0. A later rst clears underflow.
- Simultaneous boundary accesses:
  - At full, w_en=r_en=1: fill_count goes 16 -> 15 and overflow sets.
  - At empty, w_en=r_en=1 with w_data=0x55: fill_count goes 0 -> 1, underflow sets, and a later read returns 0x55.
  - Mid-level (count=8), both high for 40 cycles: fill_count stays 8 and pointers wrap past 15 with data order preserved.
- FWFT mode (FWFT=1):
  - Stimulus: write 0xA1 into empty.
  - Response: the next cycle r_valid=1 and r_data=0xA1 with no r_en. Pop, and r_valid drops the following cycle.
- Flush and reset mid-operation:
  - flush at count=7 with w_en=1: fill_count=0, r_empty=1, the concurrent write is dropped, sticky flags are retained.
  - rst asserted mid-stream: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: width helper, read-mode codes
// and the parameter legality check used by the controller.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int afull_th, input int aempty_th,
                                   input int fwft);
    return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1) &&
           ((fwft == FIFO_STD) || (fwft == FIFO_FWFT));
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_ram.sv
// Storage for sync_fifo_ctl: DATA_W x DEPTH, synchronous write, asynchronous read.
// No reset on the array; the controller's pointers define which words are live.
module sfifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: standard (1-cycle registered) or FWFT read, flags one cycle after request.
// Backpressure: writes dropped when full (overflow), pops ignored when empty (underflow); both sticky until rst.
module sync_fifo_ctl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    w_en,
  input  logic [DATA_W-1:0]       w_data,
  input  logic                    r_en,
  output logic [DATA_W-1:0]       r_data,
  output logic                    r_valid,
  output logic                    w_full,
  output logic                    w_almost_full,
  output logic                    r_empty,
  output logic                    r_almost_empty,
  output logic [clog2(DEPTH):0]   fill_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit PARAMS_OK = params_ok(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH, FWFT);

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count_nxt;
  logic              wr_acc, rd_acc, ram_we;
  logic [DATA_W-1:0] ram_rdata;

  always_ff @(posedge clk) begin
    assert (PARAMS_OK);
  end

  // Acceptance uses the registered flags, so a full FIFO still accepts a read.
  assign wr_acc = w_en & ~w_full;
  assign rd_acc = r_en & ~r_empty;
  assign ram_we = wr_acc & ~flush & ~rst;

  always_comb begin
    count_nxt = fill_count;
    if (flush) count_nxt = '0;
    else       count_nxt = fill_count + CW'(wr_acc) - CW'(rd_acc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_count     <= '0;
      w_full         <= 1'b0;
      w_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc)            wr_ptr    <= wr_ptr + AW'(1);
        if (rd_acc)            rd_ptr    <= rd_ptr + AW'(1);
        if (w_en && w_full)    overflow  <= 1'b1;
        if (r_en && r_empty)   underflow <= 1'b1;
      end
      fill_count     <= count_nxt;
      w_full         <= (count_nxt == CW'(DEPTH));
      w_almost_full  <= (count_nxt >= CW'(AFULL_TH));
      r_empty        <= (count_nxt == '0);
      r_almost_empty <= (count_nxt <= CW'(AEMPTY_TH));
    end
  end

  sfifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (w_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    // Head word is exposed directly; r_en only acknowledges the pop.
    assign r_data  = ram_rdata;
    assign r_valid = ~r_empty;
  end else begin : g_std
    logic [DATA_W-1:0] r_data_q;
    logic              r_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else if (flush) begin
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) r_data_q <= ram_rdata;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Bench for sync_fifo_ctl: queue scoreboard on a standard-mode instance plus
// directed checks on an FWFT instance.
module tb_sync_fifo_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, w_en = 1'b0, r_en = 1'b0;
  logic [31:0] w_data = '0;
  logic [31:0] r_data;
  logic        r_valid, w_full, w_almost_full, r_empty, r_almost_empty, overflow, underflow;
  logic [4:0]  fill_count;

  logic        f_flush = 1'b0, f_w_en = 1'b0, f_r_en = 1'b0;
  logic [31:0] f_w_data = '0;
  logic [31:0] f_r_data;
  logic        f_r_valid, f_w_full, f_w_almost_full, f_r_empty, f_r_almost_empty;
  logic        f_overflow, f_underflow;
  logic [4:0]  f_fill_count;

  int n_chk = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  logic [31:0] m_rdata = '0;
  bit          m_rvalid = 0, m_ovf = 0, m_udf = 0;

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DATA_W(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid), .w_full(w_full), .w_almost_full(w_almost_full),
    .r_empty(r_empty), .r_almost_empty(r_almost_empty), .fill_count(fill_count),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_ctl #(.DATA_W(32), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .flush(f_flush), .w_en(f_w_en), .w_data(f_w_data), .r_en(f_r_en),
    .r_data(f_r_data), .r_valid(f_r_valid), .w_full(f_w_full), .w_almost_full(f_w_almost_full),
    .r_empty(f_r_empty), .r_almost_empty(f_r_almost_empty), .fill_count(f_fill_count),
    .overflow(f_overflow), .underflow(f_underflow));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("r_valid", r_valid, m_rvalid);
    chk("r_data", r_data, m_rdata);
    chk("fill_count", fill_count, sz);
    chk("w_full", w_full, sz == 16);
    chk("w_almost_full", w_almost_full, sz >= 12);
    chk("r_empty", r_empty, sz == 0);
    chk("r_almost_empty", r_almost_empty, sz <= 2);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_udf);
  endtask

  // One clock of the standard-mode instance; the model is advanced from its pre-edge state.
  task automatic cycle(input bit w, input logic [31:0] d, input bit r, input bit f);
    bit wacc, racc;
    int sz;
    w_en = w; w_data = d; r_en = r; flush = f;
    @(posedge clk); #1;
    w_en = 0; r_en = 0; flush = 0;
    sz = mq.size();
    if (f) begin
      mq.delete();
      m_rvalid = 0;
    end else begin
      wacc = w && (sz != 16);
      racc = r && (sz != 0);
      if (w && sz == 16) m_ovf = 1;
      if (r && sz == 0)  m_udf = 1;
      m_rvalid = racc;
      if (racc) m_rdata = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
    check_all();
  endtask

  task automatic do_reset(input int n, input bit w);
    rst = 1; w_en = w; w_data = 32'hBAD0;
    repeat (n) @(posedge clk);
    #1;
    rst = 0; w_en = 0;
    mq.delete();
    m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
    check_all();
  endtask

  task automatic fclk();
    @(posedge clk); #1;
    f_w_en = 0; f_r_en = 0;
  endtask

  initial begin
    // Reset and fill 1..16
    do_reset(3, 0);
    for (int i = 1; i <= 16; i++) cycle(1, i, 0, 0);
    // Overflow then drain
    cycle(1, 32'hDEAD, 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 0);
    chk("drain_last", r_data, 32'd16);
    // Underflow, cleared only by reset
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    do_reset(1, 0);

    // Simultaneous access at full and at empty
    for (int i = 0; i < 16; i++) cycle(1, 32'h100 + i, 0, 0);
    cycle(1, 32'h77, 1, 0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 1, 0);
    cycle(1, 32'h55, 1, 0);
    cycle(0, 0, 1, 0);
    chk("empty_rw_data", r_data, 32'h55);

    // Mid-level streaming: pointers wrap repeatedly, count holds
    for (int i = 0; i < 8; i++) cycle(1, 32'h200 + i, 0, 0);
    for (int i = 0; i < 40; i++) cycle(1, $urandom, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 0);

    // Flush at count 7 with a concurrent write; sticky flags survive
    for (int i = 0; i < 7; i++) cycle(1, 32'h300 + i, 0, 0);
    cycle(1, 32'hF00D, 0, 1);
    cycle(1, 32'h400, 0, 0);
    cycle(0, 0, 1, 0);
    chk("post_flush_data", r_data, 32'h400);

    // Reset mid-stream with a write pending
    for (int i = 0; i < 5; i++) cycle(1, 32'h500 + i, 0, 0);
    do_reset(1, 1);
    cycle(0, 0, 0, 0);

    // FWFT instance
    chk("f_rst_valid", f_r_valid, 0);
    chk("f_rst_empty", f_r_empty, 1);
    f_w_en = 1; f_w_data = 32'hA1; fclk();
    chk("f_valid_a1", f_r_valid, 1);
    chk("f_data_a1", f_r_data, 32'hA1);
    fclk();
    chk("f_hold_valid", f_r_valid, 1);
    chk("f_hold_data", f_r_data, 32'hA1);
    f_r_en = 1; fclk();
    chk("f_pop_valid", f_r_valid, 0);
    chk("f_pop_empty", f_r_empty, 1);
    chk("f_pop_count", f_fill_count, 0);
    f_w_en = 1; f_w_data = 32'hB1; fclk();
    f_w_en = 1; f_w_data = 32'hB2; fclk();
    chk("f_head_b1", f_r_data, 32'hB1);
    f_r_en = 1; fclk();
    chk("f_head_b2", f_r_data, 32'hB2);
    chk("f_count_b2", f_fill_count, 1);
    f_r_en = 1; fclk();
    chk("f_empty_b", f_r_empty, 1);
    f_w_en = 1; f_r_en = 1; f_w_data = 32'hC3; fclk();
    chk("f_erw_count", f_fill_count, 1);
    chk("f_erw_udf", f_underflow, 1);
    chk("f_erw_data", f_r_data, 32'hC3);
    chk("f_erw_valid", f_r_valid, 1);
    chk("f_ovf", f_overflow, 0);
    chk("f_full", f_w_full, 0);
    chk("f_afull", f_w_almost_full, 0);
    chk("f_aempty", f_r_almost_empty, 1);
    f_flush = 1; fclk();
    f_flush = 0;
    chk("f_flush_empty", f_r_empty, 1);
    chk("f_flush_udf", f_underflow, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
